// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// fetch_unit_pkg
// ----------------------------------------------------------------------------
// Shared definitions for the instruction-fetch front end and control decoder:
// instruction/opcode widths, opcode constants and the fetch FSM state enum.
// Ports: none (package).
// Revision: 1.0 - initial release
// ============================================================================
package fetch_unit_pkg;

    localparam int INSTR_W  = 16;
    localparam int OPCODE_W = 5;

    localparam logic [OPCODE_W-1:0] OP_HALT = 5'b00000;
    localparam logic [OPCODE_W-1:0] OP_NOP  = 5'b00001;
    localparam logic [OPCODE_W-1:0] OP_J    = 5'b00100;
    localparam logic [OPCODE_W-1:0] OP_JAL  = 5'b00110;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_STOP  = 2'd3
    } fetch_state_e;

    // Opcode field lives in the top bits of the instruction word.
    function automatic logic [OPCODE_W-1:0] opcode_of(input logic [INSTR_W-1:0] word);
        return word[INSTR_W-1 -: OPCODE_W];
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// ============================================================================
// fetch_buffer
// ----------------------------------------------------------------------------
// Single-entry holding register for one fetched instruction and its address.
// Squash has priority over load, load over accept.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   load_i            capture instr_i/pc_i and mark valid
//   squash_i          drop the held entry (wrong path)
//   accept_i          consumer took the entry this cycle
//   instr_i, pc_i     incoming instruction word and its address
//   valid_o           entry holds a live instruction
//   instr_o, pc_o     held instruction word and its address
// Revision: 1.0 - initial release
// ============================================================================
module fetch_buffer
    import fetch_unit_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic               squash_i,
    input  logic               accept_i,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic [15:0]        pc_i,
    output logic               valid_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic [15:0]        pc_o
);

    logic               valid_q;
    logic [INSTR_W-1:0] instr_q;
    logic [15:0]        pc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= RESET_PC;
        end else if (squash_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            instr_q <= instr_i;
            pc_q    <= pc_i;
        end else if (accept_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// fetch_unit
// ----------------------------------------------------------------------------
// Instruction-fetch front end. Sequences the PC, issues single-outstanding
// requests to a variable-latency instruction memory, buffers one instruction
// for decode, applies execute redirects and stops at an accepted HALT.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   imem_req, imem_addr         request pulse and fetch address
//   imem_valid, imem_rdata      memory response strobe and data
//   instr, instr_pc             buffered instruction and its address
//   instr_pc_plus2              instr_pc + 2 (link value)
//   instr_valid, instr_ready    decode handshake
//   redirect, redirect_pc       taken branch/jump from execute
//   halted, err                 sticky HALT-accepted / misaligned-target flags
// Revision: 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [15:0]        imem_addr,
    input  logic               imem_valid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic [15:0]        instr_pc,
    output logic [15:0]        instr_pc_plus2,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               redirect,
    input  logic [15:0]        redirect_pc,
    output logic               halted,
    output logic               err
);

    fetch_state_e state_q, state_d;
    logic [15:0]  pc_q, pc_d;
    logic         kill_q, kill_d;
    logic         halted_q, halted_d;
    logic         err_q, err_d;

    logic         buf_load;
    logic         buf_squash;
    logic         accept;
    logic         redir;
    logic         req_d;

    // STOP ignores both decode handshakes and redirects.
    assign accept = instr_valid & instr_ready & (state_q != S_STOP);
    assign redir  = redirect & (state_q != S_STOP);

    fetch_buffer #(
        .RESET_PC (RESET_PC)
    ) u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (buf_load),
        .squash_i (buf_squash),
        .accept_i (accept),
        .instr_i  (imem_rdata),
        .pc_i     (pc_q),
        .valid_o  (instr_valid),
        .instr_o  (instr),
        .pc_o     (instr_pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_FETCH;
            pc_q     <= RESET_PC;
            kill_q   <= 1'b0;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            kill_q   <= kill_d;
            halted_q <= halted_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        kill_d     = kill_q;
        halted_d   = halted_q;
        err_d      = err_q;
        buf_load   = 1'b0;
        buf_squash = 1'b0;
        req_d      = 1'b0;

        case (state_q)
            S_FETCH: begin
                // A redirect this cycle would make the current pc stale, so
                // the request is held back until the new target is loaded.
                if ((!instr_valid || accept) && !redir) begin
                    req_d   = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_valid) begin
                    if (kill_q) begin
                        kill_d  = 1'b0;
                        state_d = S_FETCH;
                    end else begin
                        buf_load = 1'b1;
                        pc_d     = pc_q + 16'd2;
                        if (opcode_of(imem_rdata) == OP_HALT) begin
                            state_d = S_HOLD;
                        end else begin
                            state_d = instr_ready ? S_FETCH : S_HOLD;
                        end
                    end
                end
            end
            S_HOLD: begin
                if (accept) begin
                    if (opcode_of(instr) == OP_HALT) begin
                        state_d  = S_STOP;
                        halted_d = 1'b1;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            default: begin
                state_d = S_STOP;
            end
        endcase

        // Redirect overrides everything above, including a same-cycle
        // response, load or HALT acceptance.
        if (redir) begin
            pc_d       = redirect_pc;
            buf_squash = 1'b1;
            buf_load   = 1'b0;
            halted_d   = halted_q;
            if (redirect_pc[0]) begin
                err_d   = 1'b1;
                kill_d  = 1'b0;
                state_d = S_STOP;
            end else if ((state_q == S_WAIT) && !imem_valid) begin
                // Response still in flight: remember to drop it.
                kill_d  = 1'b1;
                state_d = S_WAIT;
            end else begin
                kill_d  = 1'b0;
                state_d = S_FETCH;
            end
        end
    end

    // Reset is asynchronous, so keep the request low while it is asserted.
    assign imem_req       = req_d & rst_n;
    assign imem_addr      = pc_q;
    assign instr_pc_plus2 = instr_pc + 16'd2;
    assign halted         = halted_q;
    assign err            = err_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// tb_fetch_unit
// ----------------------------------------------------------------------------
// Self-checking bench for fetch_unit: a cycle table for the basic stream and
// HALT, hand-written redirect/error/reset sequences, and randomized traffic
// against a behavioural reference model with a variable-latency memory.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_valid = 1'b0;
    logic [15:0] imem_rdata = 16'h0000;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic [15:0] instr_pc_plus2;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        halted;
    logic        err;

    int checks = 0;
    int errors = 0;

    fetch_unit #(.RESET_PC(16'h0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_valid     (imem_valid),
        .imem_rdata     (imem_rdata),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_pc_plus2 (instr_pc_plus2),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .halted         (halted),
        .err            (err)
    );

    always #5 clk = ~clk;

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle's inputs just after the falling edge and let outputs settle.
    task automatic cyc(input logic rdy, input logic rd, input logic [15:0] rp,
                       input logic mv, input logic [15:0] md);
        instr_ready = rdy;
        redirect    = rd;
        redirect_pc = rp;
        imem_valid  = mv;
        imem_rdata  = md;
        #1;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk1 ({tag, " imem_req"},    imem_req,    1'b0);
        chk1 ({tag, " instr_valid"}, instr_valid, 1'b0);
        chk16({tag, " instr"},       instr,       16'h0000);
        chk16({tag, " instr_pc"},    instr_pc,    16'h0000);
        chk1 ({tag, " halted"},      halted,      1'b0);
        chk1 ({tag, " err"},         err,         1'b0);
    endtask

    // Leaves rst_n released at a falling edge; the next cyc() is cycle 1.
    task automatic do_reset(input logic check);
        rst_n = 1'b0;
        cyc(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
        repeat (2) @(negedge clk);
        if (check) check_reset_outputs("reset");
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        rdy;
        logic        rd;
        logic [15:0] rp;
        logic        mv;
        logic [15:0] md;
        logic        e_req;
        logic [15:0] e_addr;
        logic        e_iv;
        logic [15:0] e_instr;
        logic [15:0] e_ipc;
        logic        e_halted;
    } vec_t;

    vec_t vq[$];

    task automatic addv(input logic rdy, input logic rd, input logic [15:0] rp,
                        input logic mv, input logic [15:0] md,
                        input logic e_req, input logic [15:0] e_addr, input logic e_iv,
                        input logic [15:0] e_instr, input logic [15:0] e_ipc,
                        input logic e_halted);
        vec_t v;
        v.rdy = rdy; v.rd = rd; v.rp = rp; v.mv = mv; v.md = md;
        v.e_req = e_req; v.e_addr = e_addr; v.e_iv = e_iv;
        v.e_instr = e_instr; v.e_ipc = e_ipc; v.e_halted = e_halted;
        vq.push_back(v);
    endtask

    // ---------------- reference model state (randomized phase) ------------
    logic [15:0] mem_tbl [64];
    logic [15:0] m_pc;
    logic        m_out, m_kill, m_bv, m_hold, m_stop, m_halted, m_err;
    logic [15:0] m_bi, m_bpc;
    logic        pend;
    int          pend_cnt;
    logic [15:0] pend_addr;

    initial begin
        logic        rdy, rd, mv, e_req, acc;
        logic [15:0] rp, md;
        int unsigned r;

        // ---------- table: basic stream (L=1), decode stall, HALT ----------
        //   rdy   rd    rp        mv    md        req   addr      iv    instr     ipc       halted
        addv(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0);
        addv(1'b1, 1'b0, 16'h0000, 1'b1, 16'h4000, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0);
        addv(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0002, 1'b1, 16'h4000, 16'h0000, 1'b0);
        addv(1'b1, 1'b0, 16'h0000, 1'b1, 16'h4000, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0);
        addv(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0004, 1'b1, 16'h4000, 16'h0002, 1'b0);
        addv(1'b1, 1'b0, 16'h0000, 1'b1, 16'h4000, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0);
        for (int i = 0; i < 5; i++)
            addv(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h4000, 16'h0004, 1'b0);
        addv(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0006, 1'b1, 16'h4000, 16'h0004, 1'b0);
        addv(1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0);
        addv(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0000, 16'h0006, 1'b0);
        addv(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0000, 16'h0006, 1'b0);
        addv(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0000, 16'h0006, 1'b0);
        addv(1'b1, 1'b1, 16'h0040, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b1);
        addv(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b1);
        addv(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b1);

        @(negedge clk);
        do_reset(1'b1);
        for (int i = 0; i < vq.size(); i++) begin
            cyc(vq[i].rdy, vq[i].rd, vq[i].rp, vq[i].mv, vq[i].md);
            chk1("tbl imem_req", imem_req, vq[i].e_req);
            if (vq[i].e_req) chk16("tbl imem_addr", imem_addr, vq[i].e_addr);
            chk1("tbl instr_valid", instr_valid, vq[i].e_iv);
            if (vq[i].e_iv) begin
                chk16("tbl instr", instr, vq[i].e_instr);
                chk16("tbl instr_pc", instr_pc, vq[i].e_ipc);
            end
            chk1("tbl halted", halted, vq[i].e_halted);
            chk1("tbl err", err, 1'b0);
            tick();
        end

        // ---------- redirect while waiting (L=3): stale response dropped ----
        do_reset(1'b0);
        cyc(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000); chk1("rw c1 req", imem_req, 1'b1); tick();
        cyc(1'b1, 1'b1, 16'h0040, 1'b0, 16'h0000); chk1("rw c2 req", imem_req, 1'b0); tick();
        cyc(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000); chk1("rw c3 req", imem_req, 1'b0); tick();
        cyc(1'b1, 1'b0, 16'h0000, 1'b1, 16'h4000); chk1("rw c4 req", imem_req, 1'b0); tick();
        cyc(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000);
        chk1("rw c5 req", imem_req, 1'b1);
        chk16("rw c5 addr", imem_addr, 16'h0040);
        chk1("rw c5 stale valid", instr_valid, 1'b0);
        tick();
        cyc(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000); chk1("rw c6 valid", instr_valid, 1'b0); tick();
        cyc(1'b1, 1'b0, 16'h0000, 1'b1, 16'h0800); tick();
        cyc(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000);
        chk1("rw c8 valid", instr_valid, 1'b1);
        chk16("rw c8 instr", instr, 16'h0800);
        chk16("rw c8 instr_pc", instr_pc, 16'h0040);
        chk16("rw c8 pc_plus2", instr_pc_plus2, 16'h0042);
        chk16("rw c8 next addr", imem_addr, 16'h0042);
        tick();

        // ---------- buffered HALT squashed by redirect -----------------------
        do_reset(1'b0);
        cyc(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000); chk1("hs c1 req", imem_req, 1'b1); tick();
        cyc(1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000); tick();
        cyc(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
        chk1("hs c3 valid", instr_valid, 1'b1);
        chk1("hs c3 no req", imem_req, 1'b0);
        tick();
        cyc(1'b1, 1'b1, 16'h0010, 1'b0, 16'h0000); tick();
        cyc(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000);
        chk1("hs c5 req", imem_req, 1'b1);
        chk16("hs c5 addr", imem_addr, 16'h0010);
        chk1("hs c5 valid", instr_valid, 1'b0);
        chk1("hs c5 halted", halted, 1'b0);
        tick();

        // ---------- misaligned redirect ---------------------------------------
        do_reset(1'b0);
        cyc(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000); tick();
        cyc(1'b0, 1'b0, 16'h0000, 1'b1, 16'h4000); tick();
        cyc(1'b0, 1'b1, 16'h0011, 1'b0, 16'h0000); chk1("mis c3 err", err, 1'b0); tick();
        cyc(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000);
        chk1("mis c4 err", err, 1'b1);
        chk1("mis c4 halted", halted, 1'b0);
        chk1("mis c4 valid", instr_valid, 1'b0);
        chk1("mis c4 req", imem_req, 1'b0);
        tick();
        cyc(1'b1, 1'b1, 16'h0020, 1'b0, 16'h0000); tick();
        cyc(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000);
        chk1("mis c6 req", imem_req, 1'b0);
        chk1("mis c6 err sticky", err, 1'b1);
        tick();

        // ---------- redirect coinciding with response, and pc wrap -------------
        do_reset(1'b0);
        cyc(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000); tick();
        cyc(1'b1, 1'b1, 16'hFFFE, 1'b1, 16'h4000); chk1("wr c2 req", imem_req, 1'b0); tick();
        cyc(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000);
        chk1("wr c3 req", imem_req, 1'b1);
        chk16("wr c3 addr", imem_addr, 16'hFFFE);
        chk1("wr c3 valid", instr_valid, 1'b0);
        tick();
        cyc(1'b1, 1'b0, 16'h0000, 1'b1, 16'h4800); tick();
        cyc(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000);
        chk16("wr c5 instr_pc", instr_pc, 16'hFFFE);
        chk16("wr c5 pc_plus2", instr_pc_plus2, 16'h0000);
        chk16("wr c5 addr", imem_addr, 16'h0000);
        chk1("wr c5 err", err, 1'b0);
        tick();

        // ---------- asynchronous reset mid-WAIT ------------------------------
        do_reset(1'b0);
        cyc(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000); tick();
        cyc(1'b1, 1'b0, 16'h0000, 1'b1, 16'h4000); tick();
        cyc(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000); tick();
        cyc(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async");

        // ---------- randomized traffic against the reference model ----------
        for (int ep = 0; ep < 12; ep++) begin
            for (int k = 0; k < 64; k++) begin
                r = $urandom;
                mem_tbl[k] = 16'(r);
                if ((r[31:27] == 5'd0) || (mem_tbl[k][15:11] == 5'd0))
                    mem_tbl[k][15:11] = (r[26:24] == 3'd0) ? 5'd0 : 5'd1;
            end
            do_reset(1'b0);
            m_pc = 16'h0000; m_out = 1'b0; m_kill = 1'b0; m_bv = 1'b0; m_hold = 1'b0;
            m_stop = 1'b0; m_halted = 1'b0; m_err = 1'b0; m_bi = 16'h0000; m_bpc = 16'h0000;
            pend = 1'b0; pend_cnt = 0; pend_addr = 16'h0000;

            for (int c = 0; c < 200; c++) begin
                rdy = ($urandom_range(0, 3) != 0);
                rd  = ($urandom_range(0, 19) == 0);
                r   = $urandom;
                case ($urandom_range(0, 9))
                    0:       rp = 16'(r) | 16'h0001;
                    1, 2:    rp = 16'hFFF0 | (16'(r) & 16'h000E);
                    default: rp = 16'(r) & 16'h007E;
                endcase
                mv = pend && (pend_cnt == 0);
                md = mv ? mem_tbl[pend_addr[6:1]] : 16'h0000;
                cyc(rdy, rd, rp, mv, md);

                // Expected request: nothing outstanding, not stopped, buffer
                // drains now or is empty, no parked instruction, no redirect.
                e_req = !m_stop && !m_out && !m_hold && (!m_bv || rdy) && !rd;
                acc   = m_bv && rdy && !m_stop;
                chk1("rnd imem_req", imem_req, e_req);
                if (e_req) chk16("rnd imem_addr", imem_addr, m_pc);
                chk1("rnd instr_valid", instr_valid, m_bv);
                if (m_bv) begin
                    chk16("rnd instr", instr, m_bi);
                    chk16("rnd instr_pc", instr_pc, m_bpc);
                    chk16("rnd pc_plus2", instr_pc_plus2, m_bpc + 16'd2);
                end
                chk1("rnd halted", halted, m_halted);
                chk1("rnd err", err, m_err);

                if (!m_stop) begin
                    if (rd) begin
                        m_pc = rp; m_bv = 1'b0; m_hold = 1'b0;
                        if (rp[0]) begin
                            m_err = 1'b1; m_stop = 1'b1;
                        end else if (m_out) begin
                            if (mv) begin m_out = 1'b0; m_kill = 1'b0; end
                            else m_kill = 1'b1;
                        end
                    end else if (e_req) begin
                        m_out = 1'b1;
                        if (acc) m_bv = 1'b0;
                    end else if (m_out) begin
                        if (mv) begin
                            m_out = 1'b0;
                            if (m_kill) m_kill = 1'b0;
                            else begin
                                m_bv = 1'b1; m_bi = md; m_bpc = m_pc;
                                m_pc = m_pc + 16'd2;
                                m_hold = (md[15:11] == 5'd0) || !rdy;
                            end
                        end
                    end else if (acc) begin
                        if (m_bi[15:11] == 5'd0) begin
                            m_halted = 1'b1; m_stop = 1'b1;
                        end
                        m_bv = 1'b0; m_hold = 1'b0;
                    end
                end

                if (mv) pend = 1'b0;
                if (imem_req) begin
                    pend = 1'b1; pend_cnt = $urandom_range(0, 2); pend_addr = imem_addr;
                end else if (pend) begin
                    pend_cnt--;
                end
                tick();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
